mem_req_sched: RTL
==================

# mem_req_sched

Request scheduler between the instruction cache, the data cache and the AXI bridge's SRAM-like ports. It serialises reads onto the bridge's single read-address channel, gives dcache reads priority over icache reads with a starvation guard, and holds one dcache write (line or word) in a buffer until the bridge completes it. It blocks any read whose cache line matches the pending write (read-after-write hazard), so refills never return stale memory.

## Interface
- OFFSET_W, 4: line offset width; line address = addr[31:OFFSET_W].
- STARVE_MAX, 3: consecutive dcache read grants, with icache waiting, before icache is forced.

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- ic_rd_req / ic_rd_type / ic_rd_addr  in  1/3/32  icache read request
- ic_rd_rdy  out  1  icache request accepted this cycle
- ic_ret_valid / ic_ret_last / ic_ret_data  out  1/1/32  icache return beat
- dc_rd_req / dc_rd_type / dc_rd_addr  in  1/3/32  dcache read request
- dc_rd_rdy  out  1  dcache read accepted
- dc_ret_valid / dc_ret_last / dc_ret_data  out  1/1/32  dcache return beat
- dc_wr_req / dc_wr_type / dc_wr_addr / dc_wr_wstrb / dc_wr_data  in  1/3/32/4/128  dcache write
- dc_wr_rdy  out  1  write buffer free
- br_inst_rd_req / br_inst_rd_type / br_inst_rd_addr  out  1/3/32  to bridge inst read port
- br_inst_rd_rdy, br_inst_ret_valid, br_inst_ret_last, br_inst_ret_data  in  1/1/1/32  from bridge
- br_data_rd_req / br_data_rd_type / br_data_rd_addr  out  1/3/32  to bridge data read port
- br_data_rd_rdy, br_data_ret_valid, br_data_ret_last, br_data_ret_data  in  1/1/1/32  from bridge
- br_data_wr_req / _type / _addr / _wstrb / _data  out  1/3/32/4/128  to bridge write port
- br_data_wr_rdy  in  1  bridge accepts write
- br_wr_done  in  1  one-cycle pulse at bvalid & bready

## Operation
- Read FSM: R_IDLE, R_DATA, R_INST. Only one read is outstanding at a time.
- In R_IDLE, a requester is eligible when its req=1 and it has no hazard.
  - Hazard: wstate != W_IDLE and rd_addr[31:OFFSET_W] == wbuf_addr[31:OFFSET_W].
- Grant selection:
  - dcache wins if eligible, unless streak == STARVE_MAX and icache is eligible.
  - Otherwise icache wins if eligible.
- Only the granted port drives its br_*_rd_req, with type and addr passed through combinationally. The other port's req stays 0.
- ic/dc_rd_rdy = grant & br_*_rd_rdy. On handshake: R_IDLE goes to R_DATA or R_INST.
- streak (2-bit counter):
  - Increments on a dcache grant while ic_rd_req=1.
  - Clears on an icache grant, or on a dcache grant while ic_rd_req=0.
  - Saturates at STARVE_MAX.
- Returns:
  - dc_ret_* = br_data_ret_* gated by rstate == R_DATA.
  - ic_ret_* = br_inst_ret_* gated by rstate == R_INST.
  - Gated outputs are 0 otherwise.
  - ret_valid & ret_last goes back to R_IDLE. A new grant is possible the next cycle.
- Write FSM: W_IDLE, W_ISSUE, W_WAIT.
  - dc_wr_rdy = aresetn & (wstate == W_IDLE).
  - dc_wr_req & dc_wr_rdy: latch type, addr, wstrb and data; go to W_ISSUE.
  - In W_ISSUE, br_data_wr_req=1 with the latched fields. br_data_wr_rdy=1 goes to W_WAIT.
  - In W_WAIT, br_wr_done goes to W_IDLE. br_wr_done in any other state is ignored.
- Reads and writes proceed concurrently. The hazard check is the only coupling between them.

## Timing
- Reset (aresetn=0 at posedge): rstate=R_IDLE, wstate=W_IDLE, streak=0, write buffer cleared.
- While aresetn=0, every output is 0, including dc_wr_rdy.
- Read request path is zero-latency combinational: req to br req, and br rdy to rdy in the same cycle.
- Write: capture in cycle N, br_data_wr_req=1 from cycle N+1, held until accepted.
- Hazard clears in the cycle after br_wr_done. A blocked read is granted at the earliest one cycle after the done pulse.
- A write captured in the same cycle as a read grant to the same line does not block that read. The read was already accepted; the hazard applies to later reads only.
- Return beats pass through with zero latency. No buffering, no back-pressure.
- Reset mid-transfer returns both FSMs to idle. In-flight bridge responses arriving afterwards are dropped.

## Test plan
- Lone icache line read 0x1C000040 (type 4): rdy in the same cycle; 4 beats forwarded; ic_ret_last on beat 4; FSM back to R_IDLE.
- dc and ic read both requested every cycle, no hazard: grants D,D,D,I,D,D,D,I (STARVE_MAX=3).
- Write line 0x00001000, then dcache read 0x0000100C: read held (br_data_rd_req=0) until the cycle after br_wr_done; read to 0x00002000 proceeds meanwhile.
- Second dc_wr_req while in W_WAIT: dc_wr_rdy=0; accepted the cycle after br_wr_done; br_data_wr_req reasserts the next cycle with the new data.
- br_data_wr_rdy held low 5 cycles: br_data_wr_req and its fields stable all 5 cycles.
- aresetn low for 1 cycle during R_INST beat 2: all outputs 0; afterwards stray br_inst_ret_valid gives ic_ret_valid=0.

Source files
------------

// File: rtl/mem_req_sched.sv
// Read/write scheduler between the L1 caches and the AXI bridge SRAM-like ports.
// One read is outstanding at a time. One write is buffered. Reads are blocked on a pending same-line write.
module mem_req_sched #(
    parameter int unsigned OFFSET_W   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         aresetn,

    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic         ic_ret_last,
    output logic [31:0]  ic_ret_data,

    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic         dc_ret_last,
    output logic [31:0]  dc_ret_data,

    input  logic         dc_wr_req,
    input  logic [2:0]   dc_wr_type,
    input  logic [31:0]  dc_wr_addr,
    input  logic [3:0]   dc_wr_wstrb,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,

    output logic         br_inst_rd_req,
    output logic [2:0]   br_inst_rd_type,
    output logic [31:0]  br_inst_rd_addr,
    input  logic         br_inst_rd_rdy,
    input  logic         br_inst_ret_valid,
    input  logic         br_inst_ret_last,
    input  logic [31:0]  br_inst_ret_data,

    output logic         br_data_rd_req,
    output logic [2:0]   br_data_rd_type,
    output logic [31:0]  br_data_rd_addr,
    input  logic         br_data_rd_rdy,
    input  logic         br_data_ret_valid,
    input  logic         br_data_ret_last,
    input  logic [31:0]  br_data_ret_data,

    output logic         br_data_wr_req,
    output logic [2:0]   br_data_wr_type,
    output logic [31:0]  br_data_wr_addr,
    output logic [3:0]   br_data_wr_wstrb,
    output logic [127:0] br_data_wr_data,
    input  logic         br_data_wr_rdy,
    input  logic         br_wr_done
);

    localparam logic [1:0] StarveMax = 2'(STARVE_MAX);

    typedef enum logic [1:0] {RIdle, RData, RInst} rstate_e;
    typedef enum logic [1:0] {WIdle, WIssue, WWait} wstate_e;

    rstate_e        rstate_q;
    wstate_e        wstate_q;
    logic [1:0]     streak_q;
    logic [2:0]     wbuf_type_q;
    logic [31:0]    wbuf_addr_q;
    logic [3:0]     wbuf_wstrb_q;
    logic [127:0]   wbuf_data_q;

    logic wr_busy;
    logic ic_hazard;
    logic dc_hazard;
    logic rd_idle;
    logic ic_elig;
    logic dc_elig;
    logic ic_grant;
    logic dc_grant;
    logic ic_hs;
    logic dc_hs;
    logic ic_ret_act;
    logic dc_ret_act;
    logic wr_issue;
    logic wr_capture;

    // Arbitration and hazard detection
    always_comb begin
        wr_busy   = (wstate_q != WIdle);
        ic_hazard = wr_busy && (ic_rd_addr[31:OFFSET_W] == wbuf_addr_q[31:OFFSET_W]);
        dc_hazard = wr_busy && (dc_rd_addr[31:OFFSET_W] == wbuf_addr_q[31:OFFSET_W]);
        rd_idle   = (rstate_q == RIdle);
        ic_elig   = aresetn && rd_idle && ic_rd_req && !ic_hazard;
        dc_elig   = aresetn && rd_idle && dc_rd_req && !dc_hazard;
        // Starvation guard: after STARVE_MAX back-to-back dcache wins, a waiting icache goes first.
        dc_grant  = dc_elig && !((streak_q == StarveMax) && ic_elig);
        ic_grant  = ic_elig && !dc_grant;
        ic_hs     = ic_grant && br_inst_rd_rdy;
        dc_hs     = dc_grant && br_data_rd_rdy;
    end

    // Read request pass-through; only the granted port sees a request
    always_comb begin
        br_inst_rd_req  = ic_grant;
        br_inst_rd_type = ic_grant ? ic_rd_type : 3'd0;
        br_inst_rd_addr = ic_grant ? ic_rd_addr : 32'd0;
        ic_rd_rdy       = ic_hs;

        br_data_rd_req  = dc_grant;
        br_data_rd_type = dc_grant ? dc_rd_type : 3'd0;
        br_data_rd_addr = dc_grant ? dc_rd_addr : 32'd0;
        dc_rd_rdy       = dc_hs;
    end

    // Return beats are forwarded only to the port that owns the outstanding read
    always_comb begin
        ic_ret_act   = aresetn && (rstate_q == RInst);
        dc_ret_act   = aresetn && (rstate_q == RData);

        ic_ret_valid = ic_ret_act && br_inst_ret_valid;
        ic_ret_last  = ic_ret_act && br_inst_ret_last;
        ic_ret_data  = ic_ret_act ? br_inst_ret_data : 32'd0;

        dc_ret_valid = dc_ret_act && br_data_ret_valid;
        dc_ret_last  = dc_ret_act && br_data_ret_last;
        dc_ret_data  = dc_ret_act ? br_data_ret_data : 32'd0;
    end

    // Write buffer outputs
    always_comb begin
        dc_wr_rdy        = aresetn && (wstate_q == WIdle);
        wr_capture       = dc_wr_rdy && dc_wr_req;
        wr_issue         = aresetn && (wstate_q == WIssue);
        br_data_wr_req   = wr_issue;
        br_data_wr_type  = wr_issue ? wbuf_type_q  : 3'd0;
        br_data_wr_addr  = wr_issue ? wbuf_addr_q  : 32'd0;
        br_data_wr_wstrb = wr_issue ? wbuf_wstrb_q : 4'd0;
        br_data_wr_data  = wr_issue ? wbuf_data_q  : 128'd0;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rstate_q     <= RIdle;
            wstate_q     <= WIdle;
            streak_q     <= 2'd0;
            wbuf_type_q  <= 3'd0;
            wbuf_addr_q  <= 32'd0;
            wbuf_wstrb_q <= 4'd0;
            wbuf_data_q  <= 128'd0;
        end else begin
            unique case (rstate_q)
                RIdle: begin
                    if (dc_hs) begin
                        rstate_q <= RData;
                    end else if (ic_hs) begin
                        rstate_q <= RInst;
                    end
                end
                RData: begin
                    if (br_data_ret_valid && br_data_ret_last) begin
                        rstate_q <= RIdle;
                    end
                end
                RInst: begin
                    if (br_inst_ret_valid && br_inst_ret_last) begin
                        rstate_q <= RIdle;
                    end
                end
                default: rstate_q <= RIdle;
            endcase

            // Streak tracks accepted dcache reads that made a waiting icache wait
            if (dc_hs) begin
                if (!ic_rd_req) begin
                    streak_q <= 2'd0;
                end else if (streak_q != StarveMax) begin
                    streak_q <= streak_q + 2'd1;
                end
            end else if (ic_hs) begin
                streak_q <= 2'd0;
            end

            unique case (wstate_q)
                WIdle: begin
                    if (wr_capture) begin
                        wbuf_type_q  <= dc_wr_type;
                        wbuf_addr_q  <= dc_wr_addr;
                        wbuf_wstrb_q <= dc_wr_wstrb;
                        wbuf_data_q  <= dc_wr_data;
                        wstate_q     <= WIssue;
                    end
                end
                WIssue: begin
                    if (br_data_wr_rdy) begin
                        wstate_q <= WWait;
                    end
                end
                WWait: begin
                    if (br_wr_done) begin
                        wstate_q <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase
        end
    end

    a_one_rd_req: assert property (@(posedge clk) disable iff (!aresetn)
        !(br_inst_rd_req && br_data_rd_req));

    a_wr_hold: assert property (@(posedge clk) disable iff (!aresetn)
        (br_data_wr_req && !br_data_wr_rdy) |=> br_data_wr_req);

endmodule
